// File: rtl/mvu_pkg.sv
// Shared definitions for the MVU data bank: write-source indices and
// elaboration-time helpers for sizing and parameter checking.
package mvu_pkg;

  localparam int SRC_INPUT    = 0;
  localparam int SRC_DATAPATH = 1;
  localparam int SRC_CTRL     = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/mvu_bank_ram.sv
// Inferred simple-dual-port RAM, read-first, registered read port with enable.
// Contents are never reset.
module mvu_bank_ram
  import mvu_pkg::*;
#(
  parameter int W = 64,
  parameter int A = 10
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         re_i,
  input  logic [A-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [2**A];
  logic [W-1:0] rdata_q;

  // A same-address write lands after the read samples, so reads see old data.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mvu_bank.sv
// MVU data bank: NSRC-way write mux, NRD-way broadcast read with 1- or
// 2-cycle latency, selectable collision policy and sticky bad-select flag.
module mvu_bank
  import mvu_pkg::*;
#(
  parameter int W           = 64,
  parameter int A           = 10,
  parameter int NSRC        = 3,
  parameter int NRD         = 3,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 0,
  parameter int SELW        = (NSRC > 1) ? clog2(NSRC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [A-1:0]      rd_addr,
  output logic              rd_valid,
  output logic [NRD*W-1:0]  rd_word,
  input  logic              wr_en,
  input  logic [A-1:0]      wr_addr,
  input  logic [SELW-1:0]   wr_sel,
  input  logic [NSRC*W-1:0] wr_words,
  output logic              wr_err
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("mvu_bank: RD_LAT must be 1 or 2");
  end

  logic [W-1:0] wr_data;
  logic         wr_legal;
  logic         wr_do;
  logic         err_q, err_d;

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(wr_sel) == k) wr_data = wr_words[k*W +: W];
    end
  end

  assign wr_legal = (int'(wr_sel) < NSRC);
  assign wr_do    = wr_en & wr_legal & ~rst;
  assign err_d    = err_q | (wr_en & ~wr_legal);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  // ---- stage p0 -> p1: RAM read, collision capture ----
  logic [W-1:0] ram_rdata;
  logic         vld_p1_q;
  logic         fwd_sel_p1_q;
  logic [W-1:0] fwd_p1_q;
  logic [W-1:0] data_p1;

  mvu_bank_ram #(.W(W), .A(A)) u_ram (
    .clk     (clk),
    .we_i    (wr_do),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      fwd_sel_p1_q <= 1'b0;
    end else begin
      vld_p1_q     <= rd_en;
      fwd_sel_p1_q <= rd_en & wr_do & (rd_addr == wr_addr) & (WRITE_FIRST != 0);
    end
    fwd_p1_q <= wr_data;
  end

  assign data_p1 = fwd_sel_p1_q ? fwd_p1_q : ram_rdata;

  // ---- stage p1 -> output: hold or register the result ----
  logic         vld_out;
  logic [W-1:0] word_out;

  if (RD_LAT == 1) begin : g_lat1
    logic [W-1:0] hold_q, hold_d;

    assign hold_d = vld_p1_q ? data_p1 : hold_q;

    always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else     hold_q <= hold_d;
    end

    assign vld_out  = vld_p1_q;
    assign word_out = hold_d;
  end else begin : g_lat2
    logic         vld_p2_q;
    logic [W-1:0] word_p2_q, word_p2_d;

    assign word_p2_d = vld_p1_q ? data_p1 : word_p2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p2_q  <= 1'b0;
        word_p2_q <= '0;
      end else begin
        vld_p2_q  <= vld_p1_q;
        word_p2_q <= word_p2_d;
      end
    end

    assign vld_out  = vld_p2_q;
    assign word_out = word_p2_q;
  end

  assign rd_valid = vld_out;
  assign rd_word  = {NRD{word_out}};
  assign wr_err   = err_q;

endmodule

// File: tb/tb_mvu_bank.sv
// Randomized bench for mvu_bank: two builds (RD_LAT=1/old-data and
// RD_LAT=2/new-data) share one stimulus stream and one reference model.
module tb_mvu_bank;
  import mvu_pkg::*;

  localparam int W    = 64;
  localparam int A    = 10;
  localparam int NSRC = 3;
  localparam int NRD  = 3;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en;
  logic [A-1:0]      rd_addr;
  logic              wr_en;
  logic [A-1:0]      wr_addr;
  logic [SELW-1:0]   wr_sel;
  logic [NSRC*W-1:0] wr_words;
  logic              rd_valid_a, rd_valid_b;
  logic [NRD*W-1:0]  rd_word_a, rd_word_b;
  logic              wr_err_a, wr_err_b;

  always #5 clk = ~clk;

  mvu_bank #(.W(W), .A(A), .NSRC(NSRC), .NRD(NRD), .RD_LAT(1), .WRITE_FIRST(0)) u_dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_a),
    .rd_word(rd_word_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
    .wr_words(wr_words), .wr_err(wr_err_a)
  );

  mvu_bank #(.W(W), .A(A), .NSRC(NSRC), .NRD(NRD), .RD_LAT(2), .WRITE_FIRST(1)) u_dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_b),
    .rd_word(rd_word_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
    .wr_words(wr_words), .wr_err(wr_err_b)
  );

  // Reference model: memory by address, expected results keyed by due cycle.
  logic [W-1:0] mem_m [int];
  logic [W-1:0] due_a [int];
  logic [W-1:0] due_b [int];
  logic [W-1:0] hold_a, hold_b;
  bit           err_m;
  int           cyc;
  int           n_cmp, n_bad;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    bit           va, vb;
    logic [W-1:0] ea, eb;
    va = due_a.exists(cyc);
    ea = va ? due_a[cyc] : hold_a;
    if (va) begin hold_a = ea; due_a.delete(cyc); end
    vb = due_b.exists(cyc);
    eb = vb ? due_b[cyc] : hold_b;
    if (vb) begin hold_b = eb; due_b.delete(cyc); end
    chk("valid_lat1", {63'd0, rd_valid_a}, {63'd0, va});
    chk("valid_lat2", {63'd0, rd_valid_b}, {63'd0, vb});
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("word_lat1[%0d]", k), rd_word_a[k*W +: W], ea);
      chk($sformatf("word_lat2[%0d]", k), rd_word_b[k*W +: W], eb);
    end
    chk("err_lat1", {63'd0, wr_err_a}, {63'd0, err_m});
    chk("err_lat2", {63'd0, wr_err_b}, {63'd0, err_m});
  endtask

  task automatic model_step();
    logic [W-1:0] wd, old;
    bit           legal;
    if (rst) begin
      due_a.delete();
      due_b.delete();
      hold_a = '0;
      hold_b = '0;
      err_m  = 1'b0;
      return;
    end
    legal = (int'(wr_sel) < NSRC);
    wd    = legal ? wr_words[int'(wr_sel)*W +: W] : '0;
    if (wr_en && !legal) err_m = 1'b1;
    if (rd_en) begin
      old = mem_m[int'(rd_addr)];
      due_a[cyc + 1] = old;
      due_b[cyc + 2] = (wr_en && legal && rd_addr == wr_addr) ? wd : old;
    end
    if (wr_en && legal) mem_m[int'(wr_addr)] = wd;
  endtask

  task automatic tick();
    if (cyc > 0) check_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input bit r, input bit re, input int ra, input bit we,
                       input int wa, input int sel, input logic [W-1:0] d);
    rst     = r;
    rd_en   = re;
    rd_addr = A'(ra);
    wr_en   = we;
    wr_addr = A'(wa);
    wr_sel  = SELW'(sel);
    for (int k = 0; k < NSRC*W/32; k++) wr_words[k*32 +: 32] = $urandom;
    if (sel < NSRC) wr_words[sel*W +: W] = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0, 0, 0, '0);
  endtask

  bit           r_r, r_re, r_we;
  int           r_ra, r_wa, r_sel;
  logic [W-1:0] r_d;

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0;
    hold_a = '0; hold_b = '0; err_m = 1'b0;
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_sel = '0; wr_words = '0;
    @(negedge clk);

    // Reset with reads requested: nothing may come out.
    drive(1'b1, 1'b1, 3, 1'b0, 0, 0, '0);
    drive(1'b1, 1'b1, 3, 1'b0, 0, 0, '0);

    // Preload every address the bench will read.
    for (int a = 0; a < 16; a++) drive(1'b0, 1'b0, 0, 1'b1, a, a % NSRC, {$urandom, $urandom});

    // One write per source, then back-to-back reads.
    drive(1'b0, 1'b0, 0, 1'b1, 5, SRC_INPUT,    {16{4'h1}});
    drive(1'b0, 1'b0, 0, 1'b1, 6, SRC_DATAPATH, {16{4'h2}});
    drive(1'b0, 1'b0, 0, 1'b1, 7, SRC_CTRL,     {16{4'h3}});
    drive(1'b0, 1'b1, 5, 1'b0, 0, 0, '0);
    drive(1'b0, 1'b1, 6, 1'b0, 0, 0, '0);
    drive(1'b0, 1'b1, 7, 1'b0, 0, 0, '0);
    idle(3);

    // Same-cycle collision on address 9, then a plain re-read.
    drive(1'b0, 1'b0, 0, 1'b1, 9, SRC_INPUT, 64'hAA);
    drive(1'b0, 1'b1, 9, 1'b1, 9, SRC_DATAPATH, 64'hBB);
    drive(1'b0, 1'b1, 9, 1'b0, 0, 0, '0);
    idle(3);

    // Illegal select must not write and must raise the sticky flag.
    drive(1'b0, 1'b0, 0, 1'b1, 4, SRC_CTRL, 64'h44);
    drive(1'b0, 1'b1, 4, 1'b1, 4, 3, '0);
    idle(2);
    drive(1'b0, 1'b1, 4, 1'b0, 0, 0, '0);
    idle(3);

    // A write after the read was issued must not affect it.
    drive(1'b0, 1'b0, 0, 1'b1, 1, SRC_INPUT, 64'h10);
    drive(1'b0, 1'b1, 1, 1'b0, 0, 0, '0);
    drive(1'b0, 1'b0, 0, 1'b1, 1, SRC_DATAPATH, 64'h99);
    idle(3);

    // Reset while reads are in flight.
    drive(1'b0, 1'b1, 2, 1'b0, 0, 0, '0);
    drive(1'b1, 1'b1, 3, 1'b1, 3, SRC_INPUT, 64'hDEAD);
    idle(3);
    drive(1'b0, 1'b1, 3, 1'b0, 0, 0, '0);
    idle(2);

    // Random traffic over a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      r_r   = ($urandom_range(0, 39) == 0);
      r_re  = 1'($urandom_range(0, 1));
      r_we  = 1'($urandom_range(0, 1));
      r_ra  = $urandom_range(0, 15);
      r_wa  = ($urandom_range(0, 2) == 0) ? r_ra : $urandom_range(0, 15);
      r_sel = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NSRC - 1);
      r_d   = {$urandom, $urandom};
      drive(r_r, r_re, r_ra, r_we, r_wa, r_sel, r_d);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mvu_bank.md
Name: mvu_bank

Overview:
- Parametrised successor to the fixed 64-bit, 3-source data bank.
- Simple-dual-port bank with:
  - NSRC muxed write sources;
  - an NRD-way broadcast read;
  - configurable read latency with a valid pipeline;
  - defined same-address read/write collision semantics;
  - a sticky error flag for illegal write selects.
- Sits between the MVU input/datapath/controller ports and replaces vendor-macro BRAM with inferred memory.

Parameters:
- W, 64, word width in bits
- A, 10, address width; depth = 2**A words
- NSRC, 3, number of write sources (index 0 = input, 1 = datapath, 2 = controller in the default build)
- NRD, 3, number of broadcast read outputs
- RD_LAT, 1, read latency in cycles, 1 or 2 (2 adds an output register)
- WRITE_FIRST, 0, same-address collision policy: 1 returns new data, 0 returns old data
- SELW, derived = max(1, clog2(NSRC)), write-select width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_en  in  1  read request
- rd_addr  in  A  read address
- rd_valid  out  1  rd_word carries a read result this cycle
- rd_word  out  NRD*W  read data, same word replicated on every W slice
- wr_en  in  1  write request
- wr_addr  in  A  write address
- wr_sel  in  SELW  write source select
- wr_words  in  NSRC*W  source words; slice k = source k
- wr_err  out  1  sticky: an illegal wr_sel was seen with wr_en

Behaviour:
- Reset values: rd_valid=0, rd_word=0, wr_err=0.
- Memory contents are not cleared by reset.
- Reset has priority over all other activity in the same cycle.
  - Reads in flight are discarded; no rd_valid results from reads issued before or during the reset cycle.
  - A write presented in a cycle with rst=1 is not performed.
- Write path:
  - Source mux: wr_data = wr_words slice wr_sel.
  - If wr_en=1 and wr_sel < NSRC: mem[wr_addr] <= wr_data at the clock edge.
  - If wr_en=1 and wr_sel >= NSRC: no write occurs, and wr_err is set the next cycle. It holds until rst.
  - wr_sel is ignored when wr_en=0.
- Read path:
  - rd_en in cycle T gives rd_valid=1 in cycle T+RD_LAT, with the data for rd_addr.
  - Each cycle with rd_en=1 produces exactly one valid cycle. Fully pipelined, throughput one read per cycle, no stall.
  - When no result is due, rd_valid=0 and rd_word holds its last value. It updates only in valid cycles.
  - Every NRD slice of rd_word is identical at all times.
- Collisions:
  - If rd_en, wr_en and a legal wr_sel occur in the same cycle with rd_addr == wr_addr:
    - WRITE_FIRST=1: the result is wr_data.
    - WRITE_FIRST=0: the result is the prior contents.
  - With an illegal wr_sel, the result is always the prior contents.
  - A write in a cycle after the read was issued (RD_LAT=2 case) never affects that read's result.
- Simultaneous reads and writes to different addresses are independent.
- Addresses wrap naturally (A bits); no range check.
- RD_LAT outside {1,2} is an elaboration error.

Decomposition:
- Shared package mvu_pkg:
  - the source index constants SRC_INPUT=0, SRC_DATAPATH=1, SRC_CTRL=2;
  - a clog2 function;
  - the RD_LAT legal-range check.
- Sub-module mvu_bank_ram:
  - inferred simple-dual-port, read-first RAM, W x 2**A;
  - registered read port with enable, latency 1, no reset.
- Top level holds:
  - the write mux and illegal-select detection;
  - the collision compare and registered forward data;
  - the valid pipeline and optional output register;
  - NRD replication.

Test Plan:
- Reset behaviour: drive rst=1 for 2 cycles while rd_en=1 -> rd_valid=0, rd_word=0 and wr_err=0 throughout. First rd_valid appears only RD_LAT cycles after the first rd_en with rst=0.
- Write/read each source (NSRC=3, W=64, RD_LAT=1):
  - Sequence: write sel=0 data 0x1111... to addr 5; sel=1 data 0x2222... to 6; sel=2 data 0x3333... to 7; then read 5,6,7 back-to-back.
  - Expect: rd_valid high for 3 consecutive cycles with those words on all 3 slices, in order.
- Collision, same cycle, addr 9 holds 0xAA, write 0xBB to 9 while reading 9:
  - WRITE_FIRST=1 -> 0xBB;
  - WRITE_FIRST=0 -> 0xAA;
  - a following read of 9 -> 0xBB in both builds.
- Illegal select (NSRC=3, SELW=2): wr_en=1, wr_sel=3, addr 4 previously 0x44 -> wr_err=1 from the next cycle and remains 1. A read of 4 returns 0x44.
- Latency 2 (RD_LAT=2): read addr 1 (0x10) in cycle T, write 0x99 to addr 1 in T+1 -> rd_valid only in T+2 with 0x10. rd_word holds 0x10 after rd_valid drops.
- Reset mid-operation (RD_LAT=2): reads issued in T and T+1, rst=1 in T+1 -> no rd_valid in T+2 or T+3. rd_word=0 in T+2.
